// File: rtl/header_extractor_if.sv
// avalon_st_if: Avalon-ST style packet bus.
//   data  : DATA_WIDTH bits, first byte on the wire at the MSB
//   valid : source has a beat
//   ready : sink accepts the beat
//   sop   : first beat of a packet
//   eop   : last beat of a packet
//   empty : number of unused trailing (LSB-side) bytes in the eop beat
// Modports: master drives the beat and samples ready; slave is the reverse.
interface avalon_st_if #(
  parameter int DATA_WIDTH = 128
);
  localparam int EMPTY_W = $clog2(DATA_WIDTH / 8);

  logic [DATA_WIDTH-1:0] data;
  logic                  valid;
  logic                  ready;
  logic                  sop;
  logic                  eop;
  logic [EMPTY_W-1:0]    empty;

  modport master (output data, valid, sop, eop, empty, input ready);
  modport slave  (input data, valid, sop, eop, empty, output ready);
endinterface

// File: rtl/header_extractor.sv
// header_extractor: strips a fixed HEADER_BYTES header from each Avalon-ST
// packet, presents it on header_data (first byte at MSB) and re-aligns the
// remaining payload so it starts at the MSB symbol of data_out.
// Ports:
//   clk, rst_n    clock, asynchronous active-low reset
//   data_in       avalon_st_if.slave, incoming packets
//   data_out      avalon_st_if.master, payload packets
//   header_data   captured header, held until the next header overwrites it
//   header_valid  header_data belongs to the packet currently being output
//   runt_err      one-cycle pulse when a packet ends inside its header
// Optional (HEADER_EXTRACT_STATS_EN defined):
//   pkt_count     completed headers, wraps at 2^32
//   runt_count    runt packets, wraps at 2^32
module header_extractor #(
  parameter int DATA_WIDTH   = 128,
  parameter int HEADER_BYTES = 22
) (
  input  logic                      clk,
  input  logic                      rst_n,
  avalon_st_if.slave                data_in,
  avalon_st_if.master               data_out,
  output logic [HEADER_BYTES*8-1:0] header_data,
  output logic                      header_valid,
  output logic                      runt_err
`ifdef HEADER_EXTRACT_STATS_EN
  ,
  output logic [31:0]               pkt_count,
  output logic [31:0]               runt_count
`endif
);
  localparam int unsigned BYTES  = DATA_WIDTH / 8;
  localparam int unsigned HB     = HEADER_BYTES;
  localparam int unsigned OFFSET = HB % BYTES;
  localparam int unsigned R      = BYTES - OFFSET;
  localparam int unsigned EW     = $clog2(BYTES);
  localparam int unsigned CW     = $clog2(HB + BYTES + 1);
  localparam int unsigned LSH    = OFFSET * 8;
  localparam int unsigned RSH    = (OFFSET == 0) ? 0 : R * 8;

  typedef enum logic [1:0] {HDR, DATA, FLUSH} state_t;

  state_t                    state_q, state_d;
  logic [CW-1:0]             cnt_q, cnt_d;
  logic [HEADER_BYTES*8-1:0] hdr_q, hdr_d;
  logic                      hv_q, hv_d;
  logic                      runt_q, runt_d;
  logic                      sop_pend_q, sop_pend_d;
  logic [DATA_WIDTH-1:0]     resid_q, resid_d;
  logic [EW:0]               rcnt_q, rcnt_d;
  int unsigned               base, vb, avail;

  always_comb begin
    state_d        = state_q;
    cnt_d          = cnt_q;
    hdr_d          = hdr_q;
    hv_d           = hv_q;
    runt_d         = 1'b0;
    sop_pend_d     = sop_pend_q;
    resid_d        = resid_q;
    rcnt_d         = rcnt_q;
    base           = 0;
    avail          = 0;
    vb             = data_in.eop ? (BYTES - 32'(data_in.empty)) : BYTES;
    data_in.ready  = 1'b0;
    data_out.valid = 1'b0;
    data_out.data  = '0;
    data_out.sop   = 1'b0;
    data_out.eop   = 1'b0;
    data_out.empty = '0;

    unique case (state_q)
      HDR: begin
        data_in.ready = 1'b1;
        hv_d          = 1'b0;
        base          = data_in.sop ? 0 : 32'(cnt_q);
        avail         = base + vb;
        if (data_in.valid) begin
          for (int unsigned i = 0; i < BYTES; i++) begin
            if ((base + i) < HB && i < vb)
              hdr_d[(HB-1-(base+i))*8 +: 8] = data_in.data[(BYTES-1-i)*8 +: 8];
          end
          if (avail >= HB) begin
            // Non-sop header beats are always full, so the completing beat
            // holds exactly OFFSET header bytes followed by payload.
            hv_d       = 1'b1;
            cnt_d      = '0;
            sop_pend_d = 1'b1;
            resid_d    = data_in.data << LSH;
            if (!data_in.eop) begin
              state_d = DATA;
            end else if (avail > HB) begin
              state_d = FLUSH;
              rcnt_d  = (EW+1)'(avail - HB);
            end
          end else if (data_in.eop) begin
            runt_d = 1'b1;
            cnt_d  = '0;
          end else begin
            cnt_d = CW'(avail);
          end
        end
      end

      DATA: begin
        data_in.ready  = data_out.ready;
        data_out.valid = data_in.valid;
        data_out.sop   = sop_pend_q;
        if (OFFSET == 0) begin
          data_out.data  = data_in.data;
          data_out.eop   = data_in.eop;
          data_out.empty = data_in.empty;
        end else begin
          data_out.data = resid_q | (data_in.data >> RSH);
          if (data_in.eop && vb <= OFFSET) begin
            data_out.eop   = 1'b1;
            data_out.empty = EW'(OFFSET - vb);
          end
        end
        if (data_in.valid && data_out.ready) begin
          sop_pend_d = 1'b0;
          resid_d    = data_in.data << LSH;
          if (data_in.eop) begin
            if (OFFSET == 0 || vb <= OFFSET) begin
              state_d = HDR;
              hv_d    = 1'b0;
            end else begin
              state_d = FLUSH;
              rcnt_d  = (EW+1)'(vb - OFFSET);
            end
          end
        end
      end

      FLUSH: begin
        data_out.valid = 1'b1;
        data_out.data  = resid_q;
        data_out.sop   = sop_pend_q;
        data_out.eop   = 1'b1;
        data_out.empty = EW'(BYTES - 32'(rcnt_q));
        if (data_out.ready) begin
          state_d    = HDR;
          hv_d       = 1'b0;
          sop_pend_d = 1'b0;
        end
      end

      default: state_d = HDR;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= HDR;
      cnt_q      <= '0;
      hdr_q      <= '0;
      hv_q       <= 1'b0;
      runt_q     <= 1'b0;
      sop_pend_q <= 1'b0;
      resid_q    <= '0;
      rcnt_q     <= '0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      hdr_q      <= hdr_d;
      hv_q       <= hv_d;
      runt_q     <= runt_d;
      sop_pend_q <= sop_pend_d;
      resid_q    <= resid_d;
      rcnt_q     <= rcnt_d;
    end
  end

  assign header_data  = hdr_q;
  assign header_valid = hv_q;
  assign runt_err     = runt_q;

`ifdef HEADER_EXTRACT_STATS_EN
  logic [31:0] pkt_cnt_q, runt_cnt_q;

  // In HDR, hv_d is only raised by the beat that completes a header.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pkt_cnt_q  <= '0;
      runt_cnt_q <= '0;
    end else begin
      if (state_q == HDR && hv_d) pkt_cnt_q <= pkt_cnt_q + 32'd1;
      if (runt_d)                 runt_cnt_q <= runt_cnt_q + 32'd1;
    end
  end

  assign pkt_count  = pkt_cnt_q;
  assign runt_count = runt_cnt_q;
`endif
endmodule

// File: tb/tb_header_extractor.sv
module tb_header_extractor;
  localparam int W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  avalon_st_if #(.DATA_WIDTH(W)) in6 ();
  avalon_st_if #(.DATA_WIDTH(W)) out6 ();
  avalon_st_if #(.DATA_WIDTH(W)) in8 ();
  avalon_st_if #(.DATA_WIDTH(W)) out8 ();

  logic [47:0] hdr6;
  logic [63:0] hdr8;
  logic        hv6, hv8, runt6, runt8;
`ifdef HEADER_EXTRACT_STATS_EN
  logic [31:0] pc6, rc6, pc8, rc8;
`endif

  header_extractor #(.DATA_WIDTH(W), .HEADER_BYTES(6)) dut6 (
    .clk(clk), .rst_n(rst_n), .data_in(in6), .data_out(out6),
    .header_data(hdr6), .header_valid(hv6), .runt_err(runt6)
`ifdef HEADER_EXTRACT_STATS_EN
    , .pkt_count(pc6), .runt_count(rc6)
`endif
  );

  header_extractor #(.DATA_WIDTH(W), .HEADER_BYTES(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .data_in(in8), .data_out(out8),
    .header_data(hdr8), .header_valid(hv8), .runt_err(runt8)
`ifdef HEADER_EXTRACT_STATS_EN
    , .pkt_count(pc8), .runt_count(rc8)
`endif
  );

  typedef struct packed {
    logic [31:0] data;
    logic        sop;
    logic        eop;
    logic [1:0]  empty;
  } beat_t;

  // hvx: 0 = header_valid never high, 1 = high exactly one cycle, 2 = high at least once
  typedef struct {
    int          sel;
    bit          tog;
    int          nin;
    beat_t       din [8];
    int          nout;
    beat_t       dout [8];
    logic [63:0] hdr;
    bit          runt;
    int          hvx;
  } vec_t;

  vec_t  vecs [9];
  beat_t q6[$];
  beat_t q8[$];
  int    checks = 0;
  int    failures = 0;
  int    hv_cnt6 = 0, hv_cnt8 = 0, rt_cnt6 = 0, rt_cnt8 = 0;
  bit    tog = 1'b0;

  function automatic beat_t mk(logic [31:0] d, logic s, logic e, logic [1:0] emp);
    beat_t b;
    b.data = d; b.sop = s; b.eop = e; b.empty = emp;
    return b;
  endfunction

  task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  task automatic check_beat(int sel, beat_t act);
    beat_t       exp;
    logic [31:0] m;
    if ((sel == 0 && q6.size() == 0) || (sel == 1 && q8.size() == 0)) begin
      checks++;
      failures++;
      $display("FAIL unexpected_beat dut%0d actual=%h required=none", sel, act);
      return;
    end
    if (sel == 0) exp = q6.pop_front();
    else          exp = q8.pop_front();
    m = exp.eop ? (32'hFFFF_FFFF << (8 * exp.empty)) : 32'hFFFF_FFFF;
    chk("out_data", act.data & m, exp.data & m);
    chk("out_sop", act.sop, exp.sop);
    chk("out_eop", act.eop, exp.eop);
    if (exp.eop) chk("out_empty", act.empty, exp.empty);
  endtask

  // Output monitor / scoreboard consumer, sampled mid-cycle.
  always @(negedge clk) begin
    if (rst_n) begin
      if (out6.valid && out6.ready) check_beat(0, mk(out6.data, out6.sop, out6.eop, out6.empty));
      if (out8.valid && out8.ready) check_beat(1, mk(out8.data, out8.sop, out8.eop, out8.empty));
      if (out6.valid && !out6.ready) chk("stall_in_ready6", in6.ready, 0);
      if (out8.valid && !out8.ready) chk("stall_in_ready8", in8.ready, 0);
      if (hv6)   hv_cnt6++;
      if (hv8)   hv_cnt8++;
      if (runt6) rt_cnt6++;
      if (runt8) rt_cnt8++;
    end
  end

  initial begin
    out6.ready = 1'b1;
    out8.ready = 1'b1;
    forever begin
      @(posedge clk); #1;
      out6.ready = tog ? ~out6.ready : 1'b1;
      out8.ready = 1'b1;
    end
  end

  task automatic set_in(int sel, beat_t b, logic v);
    if (sel == 0) begin
      in6.data = b.data; in6.sop = b.sop; in6.eop = b.eop; in6.empty = b.empty; in6.valid = v;
    end else begin
      in8.data = b.data; in8.sop = b.sop; in8.eop = b.eop; in8.empty = b.empty; in8.valid = v;
    end
  endtask

  // Entered and left at posedge+1.
  task automatic drive_beat(int sel, beat_t b);
    int  n;
    logic rdy;
    set_in(sel, b, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
      rdy = (sel == 0) ? in6.ready : in8.ready;
    end while (!rdy && n < 200);
    if (!rdy) begin
      checks++;
      failures++;
      $display("FAIL in_ready_timeout dut%0d actual=0 required=1", sel);
    end
    @(posedge clk); #1;
    set_in(sel, mk('0, 1'b0, 1'b0, 2'd0), 1'b0);
    if ($urandom_range(0, 3) == 0) begin
      @(posedge clk); #1;
    end
  endtask

  task automatic run_vec(int k);
    int hv0, rt0, n, hvd, rtd, sel;
    sel = vecs[k].sel;
    @(posedge clk); #1;
    tog = vecs[k].tog;
    hv0 = (sel == 0) ? hv_cnt6 : hv_cnt8;
    rt0 = (sel == 0) ? rt_cnt6 : rt_cnt8;
    for (int j = 0; j < vecs[k].nout; j++) begin
      if (sel == 0) q6.push_back(vecs[k].dout[j]);
      else          q8.push_back(vecs[k].dout[j]);
    end
    for (int j = 0; j < vecs[k].nin; j++) drive_beat(sel, vecs[k].din[j]);
    n = 0;
    while ((q6.size() != 0 || q8.size() != 0) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (n >= 500) begin
      checks++;
      failures++;
      $display("FAIL drain_timeout vec%0d actual=%0d required=0", k, q6.size() + q8.size());
      q6.delete();
      q8.delete();
    end
    repeat (4) @(negedge clk);
    tog = 1'b0;
    hvd = ((sel == 0) ? hv_cnt6 : hv_cnt8) - hv0;
    rtd = ((sel == 0) ? rt_cnt6 : rt_cnt8) - rt0;
    if (!vecs[k].runt) chk($sformatf("hdr_vec%0d", k), (sel == 0) ? {16'h0, hdr6} : hdr8, vecs[k].hdr);
    chk($sformatf("runt_pulses_vec%0d", k), rtd, vecs[k].runt ? 1 : 0);
    if (vecs[k].hvx == 2) chk($sformatf("hv_seen_vec%0d", k), hvd != 0, 1);
    else                  chk($sformatf("hv_cycles_vec%0d", k), hvd, vecs[k].hvx);
  endtask

  task automatic setv(int k, int sel, bit tg, int nin, int nout, logic [63:0] hdr, bit runt, int hvx);
    vecs[k].sel = sel; vecs[k].tog = tg; vecs[k].nin = nin; vecs[k].nout = nout;
    vecs[k].hdr = hdr; vecs[k].runt = runt; vecs[k].hvx = hvx;
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog actual=running required=finished");
    $fatal(1);
  end

  initial begin
    set_in(0, mk('0, 1'b0, 1'b0, 2'd0), 1'b0);
    set_in(1, mk('0, 1'b0, 1'b0, 2'd0), 1'b0);

    // Packet table (HEADER_BYTES=6 on dut6, 8 on dut8).
    setv(0, 0, 0, 4, 3, 64'h0000_0001_0203_0405, 0, 2);
    vecs[0].din[0] = mk(32'h00010203, 1, 0, 0);
    vecs[0].din[1] = mk(32'h04050607, 0, 0, 0);
    vecs[0].din[2] = mk(32'h08090A0B, 0, 0, 0);
    vecs[0].din[3] = mk(32'h0C0D0E0F, 0, 1, 0);
    vecs[0].dout[0] = mk(32'h06070809, 1, 0, 0);
    vecs[0].dout[1] = mk(32'h0A0B0C0D, 0, 0, 0);
    vecs[0].dout[2] = mk(32'h0E0F0000, 0, 1, 2);

    setv(1, 0, 0, 2, 0, 64'h0, 1, 0);
    vecs[1].din[0] = mk(32'h00010203, 1, 0, 0);
    vecs[1].din[1] = mk(32'h04AAAAAA, 0, 1, 3);

    setv(2, 0, 0, 2, 0, 64'h0000_0001_0203_0405, 0, 1);
    vecs[2].din[0] = mk(32'h00010203, 1, 0, 0);
    vecs[2].din[1] = mk(32'h0405AAAA, 0, 1, 2);

    setv(3, 0, 0, 3, 1, 64'h0000_1011_1213_1415, 0, 2);
    vecs[3].din[0] = mk(32'h10111213, 1, 0, 0);
    vecs[3].din[1] = mk(32'h14151617, 0, 0, 0);
    vecs[3].din[2] = mk(32'h1819AAAA, 0, 1, 2);
    vecs[3].dout[0] = mk(32'h16171819, 1, 1, 0);

    setv(4, 0, 0, 4, 2, 64'h0000_2021_2223_2425, 0, 2);
    vecs[4].din[0] = mk(32'h20212223, 1, 0, 0);
    vecs[4].din[1] = mk(32'h24252627, 0, 0, 0);
    vecs[4].din[2] = mk(32'h28292A2B, 0, 0, 0);
    vecs[4].din[3] = mk(32'h2CBBBBBB, 0, 1, 3);
    vecs[4].dout[0] = mk(32'h26272829, 1, 0, 0);
    vecs[4].dout[1] = mk(32'h2A2B2C00, 0, 1, 1);

    setv(5, 0, 0, 2, 1, 64'h0000_3031_3233_3435, 0, 2);
    vecs[5].din[0] = mk(32'h30313233, 1, 0, 0);
    vecs[5].din[1] = mk(32'h343536CC, 0, 1, 1);
    vecs[5].dout[0] = mk(32'h36000000, 1, 1, 3);

    setv(6, 0, 0, 4, 2, 64'h0000_5051_5253_5455, 0, 2);
    vecs[6].din[0] = mk(32'h40414243, 1, 0, 0);
    vecs[6].din[1] = mk(32'h50515253, 1, 0, 0);
    vecs[6].din[2] = mk(32'h54555657, 0, 0, 0);
    vecs[6].din[3] = mk(32'h58595A5B, 0, 1, 0);
    vecs[6].dout[0] = mk(32'h56575859, 1, 0, 0);
    vecs[6].dout[1] = mk(32'h5A5B0000, 0, 1, 2);

    vecs[7] = vecs[0];
    vecs[7].tog = 1'b1;

    setv(8, 1, 0, 8, 6, 64'hA0A1_A2A3_A4A5_A6A7, 0, 2);
    vecs[8].din[0] = mk(32'hA0A1A2A3, 1, 0, 0);
    vecs[8].din[1] = mk(32'hA4A5A6A7, 0, 0, 0);
    vecs[8].din[2] = mk(32'hB0B1B2B3, 0, 0, 0);
    vecs[8].din[3] = mk(32'hB4B5B6B7, 0, 0, 0);
    vecs[8].din[4] = mk(32'hC0C1C2C3, 0, 0, 0);
    vecs[8].din[5] = mk(32'hC4C5C6C7, 0, 0, 0);
    vecs[8].din[6] = mk(32'hD0D1D2D3, 0, 0, 0);
    vecs[8].din[7] = mk(32'hD4D5D6EE, 0, 1, 1);
    for (int j = 0; j < 6; j++) vecs[8].dout[j] = vecs[8].din[j+2];
    vecs[8].dout[0].sop = 1'b1;

    // Reset state.
    #2;
    chk("rst_hv6", hv6, 0);
    chk("rst_runt6", runt6, 0);
    chk("rst_hdr6", hdr6, 0);
    chk("rst_out_valid6", out6.valid, 0);
    chk("rst_out_sop_eop6", {out6.sop, out6.eop}, 0);
    chk("rst_in_ready6", in6.ready, 1);
    chk("rst_out_valid8", out8.valid, 0);
    chk("rst_hdr8", hdr8, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int k = 0; k < 9; k++) run_vec(k);

    // Reset asserted while dut6 is in DATA with an input beat pending.
    @(posedge clk); #1;
    q6.push_back(mk(32'h06070809, 1, 0, 0));
    drive_beat(0, mk(32'h00010203, 1, 0, 0));
    drive_beat(0, mk(32'h04050607, 0, 0, 0));
    drive_beat(0, mk(32'h08090A0B, 0, 0, 0));
    set_in(0, mk(32'h0C0D0E0F, 1'b0, 1'b1, 2'd0), 1'b1);
    #1;
    chk("pre_reset_out_valid", out6.valid, 1);
    chk("pre_reset_hv", hv6, 1);
    rst_n = 1'b0;
    #1;
    chk("mid_reset_out_valid", out6.valid, 0);
    chk("mid_reset_out_sop_eop", {out6.sop, out6.eop}, 0);
    chk("mid_reset_hv", hv6, 0);
    chk("mid_reset_runt", runt6, 0);
    chk("mid_reset_hdr", hdr6, 0);
    chk("mid_reset_pending_beats", q6.size(), 0);
    set_in(0, mk('0, 1'b0, 1'b0, 2'd0), 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    run_vec(0);
`ifdef HEADER_EXTRACT_STATS_EN
    chk("pkt_count_after_reset", pc6, 1);
    chk("runt_count_after_reset", rc6, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
